// File: rtl/alu_pkg.sv
// Shared opcode encoding for the ALU decode and the multiply/divide launch logic.
package alu_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00000;
  localparam logic [OP_W-1:0] OP_ADDU = 5'b00001;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00010;
  localparam logic [OP_W-1:0] OP_SUBU = 5'b00011;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b00100;
  localparam logic [OP_W-1:0] OP_MULU = 5'b00101;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b00110;
  localparam logic [OP_W-1:0] OP_DIVU = 5'b00111;
  localparam logic [OP_W-1:0] OP_SLT  = 5'b01000;
  localparam logic [OP_W-1:0] OP_SLTU = 5'b01001;
  localparam logic [OP_W-1:0] OP_AND  = 5'b01010;
  localparam logic [OP_W-1:0] OP_OR   = 5'b01011;
  localparam logic [OP_W-1:0] OP_XOR  = 5'b01100;
  localparam logic [OP_W-1:0] OP_NOR  = 5'b01101;
  localparam logic [OP_W-1:0] OP_LUI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_SLL  = 5'b01111;
  localparam logic [OP_W-1:0] OP_SRL  = 5'b10000;
  localparam logic [OP_W-1:0] OP_SRA  = 5'b10001;

  // Mul/Mulu/Div/Divu occupy 001xx: bit 1 selects divide, bit 0 selects unsigned.
  function automatic logic is_mdu(input logic [OP_W-1:0] op);
    return op[4:2] == 3'b001;
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return op[1];
  endfunction

  function automatic logic is_signed_op(input logic [OP_W-1:0] op);
    return !op[0];
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Unsigned iterative engine: shift-add multiply or restoring divide, one bit per cycle.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] op_y,
  input  logic [WIDTH-1:0] op_m,
  output logic             busy,
  output logic             done,
  output logic             finish,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic             mode;
  logic [WIDTH-1:0] x, y, m;
  logic [WIDTH:0]   sum, shifted, diff;

  // x holds the product high half / partial remainder; y the multiplier / quotient.
  assign sum     = {1'b0, x} + (y[0] ? {1'b0, m} : '0);
  assign shifted = {x, y[WIDTH-1]};
  assign diff    = shifted - {1'b0, m};

  assign finish = busy && (cnt == CW'(WIDTH));
  assign res_hi = x;
  assign res_lo = y;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      mode <= 1'b0;
      x    <= '0;
      y    <= '0;
      m    <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        busy <= 1'b1;
        cnt  <= '0;
        mode <= div_mode;
        x    <= '0;
        y    <= op_y;
        m    <= op_m;
      end else if (finish) begin
        busy <= 1'b0;
        done <= 1'b1;
      end else if (busy) begin
        cnt <= cnt + 1'b1;
        if (mode) begin
          x <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          y <= {y[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
          x <= sum[WIDTH:1];
          y <= {sum[0], y[WIDTH-1:1]};
        end
      end
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Combinational ALU plus launch, sign handling and HI/LO for the iterative multiply/divide unit.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       aluctr,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] add_res, sub_res;
  logic [SHW-1:0]   shamt;

  assign add_res = a + b;
  assign sub_res = a - b;
  assign shamt   = a[SHW-1:0];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (aluctr)
      OP_ADD: begin
        result = add_res;
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ADDU: result = add_res;
      OP_SUB: begin
        result = sub_res;
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUBU: result = sub_res;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, a < b};
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_LUI:  result = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLL:  result = b << shamt;
      OP_SRL:  result = b >> shamt;
      OP_SRA:  result = $unsigned($signed(b) >>> shamt);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

  // Engine works on magnitudes; signs are recorded at launch and reapplied at completion.
  logic             accept, a_neg, b_neg, finish;
  logic [WIDTH-1:0] mag_a, mag_b, res_hi, res_lo;
  logic             neg_q, rem_neg_q, div_q, dz_q;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign accept = start && !busy && is_mdu(aluctr);
  assign a_neg  = is_signed_op(aluctr) && a[WIDTH-1];
  assign b_neg  = is_signed_op(aluctr) && b[WIDTH-1];
  assign mag_a  = a_neg ? -a : a;
  assign mag_b  = b_neg ? -b : b;

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .div_mode (is_div_op(aluctr)),
    .op_y     (mag_a),
    .op_m     (mag_b),
    .busy     (busy),
    .done     (done),
    .finish   (finish),
    .res_hi   (res_hi),
    .res_lo   (res_lo)
  );

  assign prod     = {res_hi, res_lo};
  assign prod_fix = neg_q ? -prod : prod;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div_q     <= 1'b0;
      dz_q      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      if (accept) begin
        neg_q     <= a_neg ^ b_neg;
        rem_neg_q <= a_neg;
        div_q     <= is_div_op(aluctr);
        dz_q      <= (b == '0);
      end
      if (finish) begin
        if (div_q) begin
          // Remainder magnitude is |a| on divide-by-zero, so the sign fix restores a.
          lo <= dz_q ? '1 : (neg_q ? -res_lo : res_lo);
          hi <= rem_neg_q ? -res_hi : res_hi;
        end else begin
          {hi, lo} <= prod_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed-vector bench for alu_mdu at WIDTH=32.
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a, b;
  logic [4:0]   aluctr;
  logic         start;
  logic [W-1:0] result, hi, lo;
  logic         zero, ovf, busy, done;

  int checks = 0;
  int errors = 0;

  alu_mdu #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .aluctr (aluctr),
    .start  (start),
    .result (result),
    .zero   (zero),
    .ovf    (ovf),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic comb(input logic [4:0] op, input logic [W-1:0] va, input logic [W-1:0] vb);
    aluctr = op;
    a      = va;
    b      = vb;
    #1;
  endtask

  // Drive a launch now (caller is mid-cycle), then count edges after acceptance until done.
  task automatic launch(input logic [4:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                        output int edges);
    aluctr = op;
    a      = va;
    b      = vb;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        edges = n;
        break;
      end
    end
  endtask

  initial begin
    int edges;
    int pulses;
    int first_done;

    reset  = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    aluctr = OP_ADD;
    #12;
    check("reset_hi", {32'h0, hi}, 64'h0);
    check("reset_lo", {32'h0, lo}, 64'h0);
    check("reset_busy_done", {62'h0, busy, done}, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    comb(OP_SRA, 32'd4, 32'hF000_0000);
    check("sra", {32'h0, result}, 64'hFF00_0000);
    comb(OP_SLT, 32'hFFFF_FFFF, 32'd1);
    check("slt", {32'h0, result}, 64'h1);
    comb(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
    check("sltu", {32'h0, result}, 64'h0);
    comb(OP_ADD, 32'h7FFF_FFFF, 32'd1);
    check("add_ovf", {31'h0, ovf, zero, result}, {31'h0, 1'b1, 1'b0, 32'h8000_0000});
    comb(OP_ADDU, 32'h7FFF_FFFF, 32'd1);
    check("addu_no_ovf", {31'h0, ovf, zero, result}, {31'h0, 1'b0, 1'b0, 32'h8000_0000});
    comb(OP_SUB, 32'd5, 32'd5);
    check("sub_zero", {31'h0, ovf, zero, result}, {31'h0, 1'b0, 1'b1, 32'h0});
    comb(OP_SUB, 32'h8000_0000, 32'd1);
    check("sub_ovf", {31'h0, ovf, zero, result}, {31'h0, 1'b1, 1'b0, 32'h7FFF_FFFF});
    comb(OP_LUI, 32'd0, 32'hABCD_1234);
    check("lui", {32'h0, result}, 64'h1234_0000);
    comb(OP_NOR, 32'h0F0F_0000, 32'h0000_00FF);
    check("nor", {32'h0, result}, 64'hF0F0_FF00);
    comb(OP_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0);
    check("xor", {32'h0, result}, 64'hF0F0_F0F0);
    comb(OP_SLL, 32'd8, 32'd1);
    check("sll", {32'h0, result}, 64'h100);
    comb(OP_SRL, 32'd4, 32'hF000_0000);
    check("srl", {32'h0, result}, 64'h0F00_0000);
    comb(5'b11111, 32'h1234, 32'h5678);
    check("illegal_op", {32'h0, result}, 64'h0);
    comb(OP_MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    check("mul_comb_zero", {31'h0, ovf, zero, result}, {31'h0, 1'b0, 1'b1, 32'h0});

    @(negedge clk);
    launch(OP_MUL, 32'hFFFF_FFFE, 32'd3, edges);
    check("mul_latency", edges, 33);
    check("mul_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    check("mul_busy_clear", {63'h0, busy}, 64'h0);
    // Back-to-back: start driven while done is high.
    launch(OP_MULU, 32'hFFFF_FFFE, 32'd3, edges);
    check("mulu_b2b_latency", edges, 33);
    check("mulu_hilo", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
    @(posedge clk);
    #1;
    check("done_one_cycle", {63'h0, done}, 64'h0);

    @(negedge clk);
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2, edges);
    check("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    @(negedge clk);
    launch(OP_DIVU, 32'd7, 32'd0, edges);
    check("divu_by_zero", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
    @(negedge clk);
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd0, edges);
    check("div_by_zero_neg", {hi, lo}, 64'hFFFF_FFF9_FFFF_FFFF);
    @(negedge clk);
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, edges);
    check("div_min_by_m1", {hi, lo}, 64'h0000_0000_8000_0000);
    @(negedge clk);
    launch(OP_DIV, 32'd7, 32'hFFFF_FFFE, edges);
    check("div_pos_by_neg", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
    @(negedge clk);
    launch(OP_MUL, 32'h8000_0000, 32'h8000_0000, edges);
    check("mul_min_min", {hi, lo}, 64'h4000_0000_0000_0000);

    // Start while busy at E5 must be ignored.
    @(negedge clk);
    aluctr = OP_MUL;
    a      = 32'd6;
    b      = 32'd7;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    pulses     = 0;
    first_done = -1;
    for (int n = 1; n <= 45; n++) begin
      if (n == 5) begin
        aluctr = OP_DIVU;
        a      = 32'd100;
        b      = 32'd3;
        start  = 1'b1;
      end
      @(posedge clk);
      #1;
      if (n == 5) start = 1'b0;
      if (done) begin
        pulses++;
        if (first_done < 0) first_done = n;
      end
    end
    check("busy_start_pulses", pulses, 1);
    check("busy_start_latency", first_done, 33);
    check("busy_start_hilo", {hi, lo}, 64'd42);

    // Reset pulse at E10 of a Mul aborts it.
    @(negedge clk);
    aluctr = OP_MUL;
    a      = 32'd9;
    b      = 32'd9;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("reset_abort_busy", {63'h0, busy}, 64'h0);
    check("reset_abort_hilo", {hi, lo}, 64'h0);
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("reset_no_done", pulses, 0);
    check("reset_hilo_hold", {hi, lo}, 64'h0);

    // First start after reset release is accepted at the very next edge.
    reset = 1'b1;
    #2;
    @(negedge clk);
    reset = 1'b0;
    launch(OP_DIVU, 32'd100, 32'd7, edges);
    check("post_reset_latency", edges, 33);
    check("divu_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
